// File: rtl/rr_debug_cmd_slave.sv
// Debug-command slave: captures per-channel readback, shifts it out on tdo, latches scanned word on jdo, pulses take_*.
// Latency: jdo and the take_* pulse appear the cycle after vs_udr; busy rises two cycles after vs_udr.
// Backpressure: with RR_DBG_CMD_SLAVE_ACK_EN defined, updates are refused (scan_err) until ack[ir_q]; otherwise none.
module rr_debug_cmd_slave #(
  parameter int IR_W   = 2,
  parameter int DR_W   = 38,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tck_en,
  input  logic                     tdi,
  output logic                     tdo,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_cdr,
  input  logic                     vs_sdr,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [NUM_CH*DR_W-1:0]   cap_data,
  input  logic [NUM_CH-1:0]        ack,
  output logic [DR_W-1:0]          jdo,
  output logic [IR_W-1:0]          ir_q,
  output logic [NUM_CH-1:0]        take_action,
  output logic [NUM_CH-1:0]        take_no_action,
  output logic                     busy,
  output logic                     scan_err
);

  // Counter must hold 0..DR_W+1 so long scans remain distinguishable from exact ones.
  localparam int CW = $clog2(DR_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PULSE, WAIT_ACK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DR_W-1:0]   sr;
  logic [CW-1:0]     cnt;
  logic [DR_W-1:0]   cap_sel;
  logic              ch_ok;
  logic [NUM_CH-1:0] ch_onehot;
  logic              do_uir;
  logic              do_udr;
  logic              do_cdr;
  logic              do_shift;
  logic              upd_ok;
  logic              upd_bad;
`ifdef RR_DBG_CMD_SLAVE_ACK_EN
  logic              ack_sel;
`else
  logic              unused_ack;
  assign unused_ack = ^ack;
`endif

  // Decode the latched instruction: selected capture word, range check, one-hot channel.
  always_comb begin
    cap_sel   = '0;
    ch_ok     = 1'b0;
    ch_onehot = '0;
`ifdef RR_DBG_CMD_SLAVE_ACK_EN
    ack_sel   = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (ir_q == IR_W'(c)) begin
        cap_sel      = cap_data[c*DR_W +: DR_W];
        ch_ok        = 1'b1;
        ch_onehot[c] = 1'b1;
`ifdef RR_DBG_CMD_SLAVE_ACK_EN
        ack_sel      = ack[c];
`endif
      end
    end
  end

  // Strobe priority: update-IR, then update-DR, then capture-DR, then shift.
  assign do_uir   = vs_uir;
  assign do_udr   = vs_udr & ~vs_uir;
  assign do_cdr   = vs_cdr & ~vs_uir & ~vs_udr;
  assign do_shift = vs_sdr & tck_en & ~vs_uir & ~vs_udr & ~vs_cdr;

  // An out-of-range channel never produces an update or an error.
  assign upd_ok  = do_udr & ch_ok & (cnt == CNT_FULL) & (state != WAIT_ACK);
  assign upd_bad = do_udr & ch_ok & ~upd_ok;

  // Scan datapath, instruction latch, sticky error and the registered command pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr             <= '0;
      cnt            <= '0;
      jdo            <= '0;
      ir_q           <= '0;
      scan_err       <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (upd_ok &  sr[DR_W-1]) ? ch_onehot : '0;
      take_no_action <= (upd_ok & ~sr[DR_W-1]) ? ch_onehot : '0;
      if (do_uir) begin
        ir_q     <= ir_in;
        scan_err <= 1'b0;
        cnt      <= '0;
      end else if (do_udr) begin
        if (upd_ok)  jdo      <= sr;
        if (upd_bad) scan_err <= 1'b1;
      end else if (do_cdr) begin
        sr  <= cap_sel;
        cnt <= '0;
      end else if (do_shift) begin
        sr  <= {tdi, sr[DR_W-1:1]};
        cnt <= (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
      end
    end
  end

  // Command FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command FSM next-state: PULSE marks the pulse cycle, WAIT_ACK holds off further updates.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (upd_ok)      state_nxt = PULSE;
        else if (do_cdr) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (do_udr) state_nxt = upd_ok ? PULSE : IDLE;
      end
      PULSE: begin
        if (upd_ok) begin
          state_nxt = PULSE;
        end else begin
`ifdef RR_DBG_CMD_SLAVE_ACK_EN
          state_nxt = WAIT_ACK;
`else
          state_nxt = do_cdr ? SHIFT : IDLE;
`endif
        end
      end
      WAIT_ACK: begin
`ifdef RR_DBG_CMD_SLAVE_ACK_EN
        if (ack_sel) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tdo = sr[0];

`ifdef RR_DBG_CMD_SLAVE_ACK_EN
  assign busy = (state == WAIT_ACK);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: doc/rr_debug_cmd_slave.md
# rr_debug_cmd_slave

Parametrised debug-command slave for the Nios II debug path, running entirely in the system clock domain. It takes virtual-JTAG state strobes and serial data that are already synchronised to `clk`, captures per-channel readback words, shifts them out on `tdo`, and latches the scanned-in word onto `jdo`. It then emits per-channel `take_action` / `take_no_action` pulses. This generation adds configurable IR/DR width, channel count, scan-length checking, and an optional acknowledge handshake.

## Interface
Parameters:
- `IR_W`, 2, instruction register width.
- `DR_W`, 38, data (shift) register width; `jdo` width.
- `NUM_CH`, 4, number of command channels; must be ≤ 2**IR_W.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `tck_en`  in  1  one-cycle pulse per JTAG bit time.
- `tdi`  in  1  serial data in, valid when `tck_en`.
- `tdo`  out  1  serial data out; equals `sr[0]`.
- `ir_in`  in  IR_W  instruction value, sampled on `vs_uir`.
- `vs_cdr`, `vs_sdr`, `vs_udr`, `vs_uir`  in  1 each  virtual state strobes: capture-DR, shift-DR, update-DR, update-IR.
- `cap_data`  in  NUM_CH*DR_W  per-channel capture words; channel c occupies `[c*DR_W +: DR_W]`.
- `ack`  in  NUM_CH  per-channel command acknowledge (used only with the ACK macro).
- `jdo`  out  DR_W  last accepted update word.
- `ir_q`  out  IR_W  latched instruction.
- `take_action`  out  NUM_CH  one-cycle pulse: command with `jdo[DR_W-1]`=1.
- `take_no_action`  out  NUM_CH  one-cycle pulse: command with `jdo[DR_W-1]`=0.
- `busy`  out  1  waiting for `ack`.
- `scan_err`  out  1  sticky: short/long scan or update while busy.

## Operation
- Reset values: `sr`=0, `jdo`=0, `ir_q`=0, `tdo`=0, `take_*`=0, `busy`=0, `scan_err`=0, bit counter=0, state=IDLE.
- Strobe priority in a single cycle: `reset` > `vs_uir` > `vs_udr` > `vs_cdr` > shift.
- `vs_uir`: `ir_q`←`ir_in`; clears `scan_err`; bit counter←0.
- `vs_cdr`:
  - If `ir_q` < NUM_CH, `sr`←channel `ir_q` of `cap_data`; otherwise `sr`←0 (bypass).
  - Bit counter←0.
- Shift (`vs_sdr` & `tck_en`): `sr`←{`tdi`, `sr[DR_W-1:1]`}.
  - Counter increments and saturates at DR_W+1.
- `vs_udr`: the update is valid iff counter==DR_W, `ir_q` < NUM_CH, and state is not WAIT_ACK.
  - Valid update: `jdo`←`sr`; the next cycle pulses `take_action[ir_q]` or `take_no_action[ir_q]`, selected by `sr[DR_W-1]`.
  - Invalid counter, or update while WAIT_ACK: `jdo` unchanged, no pulse, `scan_err`←1.
  - `ir_q` ≥ NUM_CH: silently ignored.
- States:
  - IDLE: entered on reset; goes to SHIFT on `vs_cdr`.
  - SHIFT: on `vs_udr`, goes to PULSE if the update is valid, otherwise to IDLE. On `vs_cdr`, stays in SHIFT with a re-capture.
  - PULSE: one cycle, drives the pulse. Goes to WAIT_ACK (macro defined) or IDLE.
  - WAIT_ACK: `busy`=1; returns to IDLE on `ack[ir_q]`. A `vs_cdr` here captures and shifts normally, but the state stays WAIT_ACK until ack.
- Exactly one bit of `take_action | take_no_action` is high in any cycle, or none.

## Timing
- `tdo` is registered and reflects `sr[0]` in the cycle after each capture or shift.
- `vs_udr` at cycle N → `jdo` valid at N+1 → pulse high during N+1 only.
- `busy` rises at N+2. It falls in the cycle after `ack` is sampled high; `ack` is sampled in WAIT_ACK only.
- `ack` may arrive as early as N+2. An `ack` arriving in PULSE (N+1) is ignored.
- A reset during SHIFT or WAIT_ACK aborts the scan: all outputs return to reset values next cycle and `jdo` is cleared.

## Configuration
- `RR_DBG_CMD_SLAVE_ACK_EN` defined: the WAIT_ACK state and `ack` input are active, and `busy` operates as above.
- Not defined: PULSE returns directly to IDLE; `busy` is tied 0; `ack` is ignored; back-to-back updates are always accepted.

## Test plan
- Capture/shift: IR_W=2, DR_W=38, `ir_in`=1, `cap_data` ch1=38'h2_1234_5678. Run uir, cdr, then 38 shifts with `tdi`=0 → `tdo` sequence is the LSB-first bits of 0x2_1234_5678.
- Action: shift in 38'h20_0000_00AB after uir `ir_in`=2, then udr → `jdo`=38'h20_0000_00AB next cycle, `take_action[2]` pulses once, `take_no_action`=0.
- Short scan: 37 shifts then udr → `jdo` unchanged, no pulse, `scan_err`=1. A following uir clears `scan_err`.
- Handshake (macro on): valid update on ch0 → `busy`=1 from N+2. A second udr before `ack[0]` → no pulse and `scan_err`=1. `ack[0]` → `busy`=0 next cycle.
- Bypass: `ir_in`=3 with NUM_CH=3 → capture loads 0, udr yields no pulse, `scan_err` stays 0.
- Reset mid-scan: assert `reset` after 20 shifts → `jdo`=0, state IDLE. A subsequent full 38-bit scan completes normally.
